// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the IF/LS memory port arbiter: FSM state encoding,
// owner encoding, wait-counter width and default timing constants.
// No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // MEM_LAT is at most 15, so MEM_LAT-1 always fits in four bits.
  localparam int WAIT_CNT_W     = 4;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

endpackage : arb_pkg

// File: rtl/arb_wait_counter.sv
// -----------------------------------------------------------------------------
// arb_wait_counter
// Loadable down-counter that times the memory wait states of one access.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (count -> 0)
//   i_load     in   load i_load_val (takes precedence over i_dec)
//   i_load_val in   value to load
//   i_dec      in   decrement by one (holds at zero)
//   o_zero     out  count is zero
// -----------------------------------------------------------------------------
module arb_wait_counter
  import arb_pkg::*;
#(
  parameter int CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule : arb_wait_counter

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (LS). One access at a time: grant in IDLE, MEM_LAT wait cycles in
// ACCESS with the bus held stable from latched registers, one RESP cycle that
// pulses the owner's rvalid. LS has priority over IF.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   - after STARVE_MAX consecutive LS grants made while IF was
//               waiting, IF wins the next contended arbitration.
//   undefined - strict LS priority.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rdata/if_rvalid        fetch grant pulse, data, data-valid pulse
//   ls_req/ls_we/ls_mask/ls_addr/ls_wdata  load/store request
//   ls_gnt/ls_rdata/ls_rvalid        LS grant pulse, load data, done pulse
//   mem_en/mem_we/mem_mask/mem_addr/mem_wdata  memory control/write bus
//   mem_rdata                        memory read data (valid in last wait cycle)
//   busy                             access in flight (ACCESS or RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_mask,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_rvalid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  if ((MEM_LAT < 1) || (MEM_LAT > 15) || (STARVE_MAX < 1)) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX >= 1");
  end

  arb_state_t          r_state;
  logic                r_owner;
  logic                r_we;
  logic [MASK_W-1:0]   r_mask;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;

  logic                w_idle;
  logic                w_access;
  logic                w_if_prio;
  logic                w_grant_if;
  logic                w_grant_ls;
  logic                w_wait_zero;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] r_starve_cnt;

  // Counts LS grants that made a waiting fetch lose; any IF grant or an
  // idle cycle without a fetch pending ends the starvation episode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_idle && !if_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ls && if_req && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_if_prio = (r_starve_cnt == SC_W'(STARVE_MAX));
`else
  assign w_if_prio = 1'b0;
`endif

  // Grants are combinational so the requester sees gnt in the cycle it is
  // accepted; gated by rst so every output is low while reset is held.
  assign w_grant_ls = !rst && w_idle && ls_req && (!if_req || !w_if_prio);
  assign w_grant_if = !rst && w_idle && if_req && (!ls_req || w_if_prio);

  arb_wait_counter #(
    .CNT_W (WAIT_CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_grant_if || w_grant_ls),
    .i_load_val (WAIT_CNT_W'(MEM_LAT - 1)),
    .i_dec      (w_access),
    .o_zero     (w_wait_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_mask     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ls) begin
            r_owner <= OWN_LS;
            r_we    <= ls_we;
            r_mask  <= ls_mask;
            r_addr  <= ls_addr;
            r_wdata <= ls_wdata;
            r_state <= ST_ACCESS;
          end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_mask  <= '1;
            r_addr  <= if_addr;
            r_wdata <= '0;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_wait_zero) begin
            // Stores leave ls_rdata untouched.
            if (r_owner == OWN_IF) begin
              r_if_rdata <= mem_rdata;
            end else if (!r_we) begin
              r_ls_rdata <= mem_rdata;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The memory bus is quiet outside ACCESS; mem_en drops as soon as the
  // asynchronous reset clears r_state.
  assign mem_en    = w_access;
  assign mem_we    = w_access ? r_we    : 1'b0;
  assign mem_mask  = w_access ? r_mask  : '0;
  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_wdata = w_access ? r_wdata : '0;

  assign if_gnt    = w_grant_if;
  assign ls_gnt    = w_grant_ls;
  assign if_rvalid = (r_state == ST_RESP) && (r_owner == OWN_IF);
  assign ls_rvalid = (r_state == ST_RESP) && (r_owner == OWN_LS);
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign busy      = !w_idle;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with a scoreboard: the driver pushes the expected grant
// sequence (owner, bus contents, read data) into a queue; the monitor pops an
// entry on each grant, checks the memory bus every ACCESS cycle and the
// response on rvalid. The memory model returns addr ^ 0xA5A5_0000.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = DATA_W / 8;
  localparam int MEM_LAT = 2;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              ls_req;
  logic              ls_we;
  logic [MASK_W-1:0] ls_mask;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [MASK_W-1:0] mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rdata  (if_rdata),
    .if_rvalid (if_rvalid),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_mask   (ls_mask),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rdata  (ls_rdata),
    .ls_rvalid (ls_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_mask  (mem_mask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_rdata = mem_en ? (mem_addr ^ 32'hA5A5_0000) : 32'h0;

  typedef struct {
    bit                is_ls;
    bit                we;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                gap;   // required grant cycle relative to last rvalid, -1 = any
  } exp_t;

  exp_t              gnt_q[$];
  exp_t              cur;
  bit                active;
  int                cyc;
  int                gcyc;
  int                last_rv;
  int                en_cnt;
  logic [DATA_W-1:0] last_ls;
  int                n_tests;
  int                n_fail;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    active  = 0;
    cyc     = 0;
    gcyc    = 0;
    last_rv = -1;
    en_cnt  = 0;
    last_ls = '0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_ctl", 128'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, busy, mem_mask}), 128'd0);
      chk("reset_bus", 128'({mem_addr, mem_wdata}), 128'd0);
      chk("reset_rdata", 128'({if_rdata, ls_rdata}), 128'd0);
      gnt_q.delete();
      active  = 0;
      cyc     = 0;
      last_rv = -1;
      last_ls = '0;
    end else begin
      if (!busy) chk("en_in_idle", 128'(mem_en), 128'd0);
      if (if_gnt || ls_gnt) begin
        chk("one_gnt", 128'(if_gnt & ls_gnt), 128'd0);
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", 128'd1, 128'd0);
        end else begin
          cur = gnt_q.pop_front();
          chk("gnt_owner", 128'(ls_gnt), 128'(cur.is_ls));
          if (cur.gap >= 0) chk("gnt_cycle", 128'(cyc), 128'(last_rv + cur.gap));
          active = 1;
          gcyc   = cyc;
          en_cnt = 0;
        end
      end
      if (mem_en) begin
        chk("en_active", 128'(active), 128'd1);
        chk("mem_bus", 128'({mem_we, mem_mask, mem_addr, mem_wdata}),
            128'({cur.we, cur.mask, cur.addr, cur.wdata}));
        en_cnt++;
      end
      if (if_rvalid || ls_rvalid) begin
        chk("one_rvalid", 128'(if_rvalid & ls_rvalid), 128'd0);
        if (!active) begin
          chk("unexpected_rvalid", 128'd1, 128'd0);
        end else begin
          chk("rv_owner", 128'(ls_rvalid), 128'(cur.is_ls));
          chk("rv_cycle", 128'(cyc), 128'(gcyc + MEM_LAT + 1));
          chk("en_cycles", 128'(en_cnt), 128'(MEM_LAT));
          if (!cur.is_ls) begin
            chk("if_rdata", 128'(if_rdata), 128'(cur.rdata));
          end else if (!cur.we) begin
            chk("ls_rdata", 128'(ls_rdata), 128'(cur.rdata));
            last_ls = cur.rdata;
          end else begin
            chk("store_ls_rdata_kept", 128'(ls_rdata), 128'(last_ls));
          end
          active  = 0;
          last_rv = cyc;
        end
      end
      cyc++;
    end
  end

  // ---------------- driver ----------------
  function automatic void push(bit is_ls, bit we, logic [MASK_W-1:0] mask, logic [ADDR_W-1:0] addr,
                               logic [DATA_W-1:0] wdata, logic [DATA_W-1:0] rdata, int gap);
    exp_t e;
    e.is_ls = is_ls;
    e.we    = we;
    e.mask  = mask;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = rdata;
    e.gap   = gap;
    gnt_q.push_back(e);
  endfunction

  task automatic wait_gnt(input bit ls, input bit drop);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ls ? ls_gnt : if_gnt) begin
        @(posedge clk);
        #1;
        if (drop) begin
          if (ls) ls_req = 1'b0;
          else    if_req = 1'b0;
        end
        return;
      end
    end
    $display("FAIL wait_gnt: no grant within 64 cycles (ls=%0d)", ls);
    $fatal(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((gnt_q.size() == 0) && !active) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL drain: scoreboard not empty after 100 cycles (%0d queued)", gnt_q.size());
    $fatal(1);
  endtask

  initial begin
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_mask  = 4'hF;
    ls_addr  = '0;
    ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset defaults: fetch from 0x10 immediately after release.
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'hA5A5_0010, 1);
    if_addr = 32'h10;
    if_req  = 1'b1;
    wait_gnt(0, 1);
    drain();

    // Contention: LS load wins, IF follows in the idle cycle after ls_rvalid.
    push(1, 0, 4'hF, 32'h100, 32'h0, 32'hA5A5_0100, -1);
    push(0, 0, 4'hF, 32'h20, 32'h0, 32'hA5A5_0020, 1);
    if_addr = 32'h20;
    ls_addr = 32'h100;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    wait_gnt(1, 1);
    wait_gnt(0, 1);
    drain();

    // Store with partial mask; ls_rdata must keep the 0x100 load data.
    push(1, 1, 4'b0011, 32'h30, 32'hDEAD_BEEF, 32'h0, -1);
    ls_we    = 1'b1;
    ls_mask  = 4'b0011;
    ls_addr  = 32'h30;
    ls_wdata = 32'hDEAD_BEEF;
    ls_req   = 1'b1;
    wait_gnt(1, 1);
    ls_we    = 1'b0;
    ls_mask  = 4'hF;
    ls_wdata = '0;
    drain();

    // Requester inputs change after grant; the access keeps 0x200.
    push(1, 0, 4'hF, 32'h200, 32'h0, 32'hA5A5_0200, -1);
    ls_addr = 32'h200;
    ls_req  = 1'b1;
    wait_gnt(1, 0);
    ls_req   = 1'b0;
    ls_addr  = 32'h300;
    ls_we    = 1'b1;
    ls_mask  = 4'b1000;
    ls_wdata = 32'hFFFF_FFFF;
    drain();
    ls_we    = 1'b0;
    ls_mask  = 4'hF;
    ls_wdata = '0;

    // Starvation: both requesters held continuously.
    if_addr = 32'h80;
    ls_addr = 32'h40;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) push(1, 0, 4'hF, 32'h40, 32'h0, 32'hA5A5_0040, (k == 0) ? -1 : 1);
    push(0, 0, 4'hF, 32'h80, 32'h0, 32'hA5A5_0080, 1);
    if_req = 1'b1;
    ls_req = 1'b1;
    for (int k = 0; k < 4; k++) wait_gnt(1, 0);
    wait_gnt(0, 1);
    ls_req = 1'b0;
`else
    for (int k = 0; k < 6; k++) push(1, 0, 4'hF, 32'h40, 32'h0, 32'hA5A5_0040, (k == 0) ? -1 : 1);
    push(0, 0, 4'hF, 32'h80, 32'h0, 32'hA5A5_0080, 1);
    if_req = 1'b1;
    ls_req = 1'b1;
    for (int k = 0; k < 6; k++) wait_gnt(1, 0);
    ls_req = 1'b0;
    wait_gnt(0, 1);
`endif
    drain();

    // Async reset in the first ACCESS cycle: access abandoned, no rvalid.
    push(1, 0, 4'hF, 32'h60, 32'h0, 32'hA5A5_0060, -1);
    ls_addr = 32'h60;
    ls_req  = 1'b1;
    wait_gnt(1, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'hA5A5_0010, 1);
    if_addr = 32'h10;
    if_req  = 1'b1;
    wait_gnt(0, 1);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and load/store (LS) in the staged RV32I core.
- Accepts one request per access and sequences the memory through a fixed-wait-state access.
- Returns read data or a store acknowledge to the winning requester.
- Sits between the fetch/memory stages and the memory macro. LS is driven from the decoder's store/load/mem_en path.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; the byte mask is DATA_W/8 bits
- MEM_LAT, 2, memory wait cycles per access; legal range 1..15
- STARVE_MAX, 4, consecutive LS grants allowed while IF waits (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rdata  out  DATA_W  fetched instruction
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_mask  in  DATA_W/8  byte enables for stores
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle pulse: LS request accepted
- ls_rdata  out  DATA_W  load data
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_mask  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last wait cycle
- busy  out  1  high while an access is in flight

Behaviour:
- Reset: all outputs 0; FSM=IDLE; wait counter=0; owner=IF; starve counter=0.
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: access in flight; a counter loads MEM_LAT-1 and decrements each cycle.
  - RESP: response cycle.
- IDLE, grant rules:
  - Only one requester active: it is granted.
  - Both active: LS wins (strict priority, subject to the optional feature).
  - On grant, in the same cycle: pulse the winner's gnt; latch the winner's addr/we/mask/wdata and owner; go to ACCESS.
  - Fetch grants force we=0 and mask=all-ones.
- ACCESS:
  - Drive mem_en=1 and mem_we/mask/addr/wdata from the latched registers every cycle. These must be stable for the whole access.
  - When the counter reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Pulse the owner's rvalid for one cycle; mem_en=0; return to IDLE.
  - For stores, ls_rdata is unchanged; rvalid means the write has completed.
- rdata registers hold their value until the next capture for the same owner.
- busy=1 in ACCESS and RESP.
- Latency: grant at cycle t; rvalid at t+MEM_LAT+1; next grant no earlier than t+MEM_LAT+2.
- A request that arrives during ACCESS/RESP waits; no gnt is issued outside IDLE.
- Requester inputs are ignored after gnt; changes after the grant do not affect the access in flight.
- A request dropped before gnt is legal and is simply never served.
- Reset mid-access: the access is abandoned immediately; mem_en=0 asynchronously; no rvalid is issued. Memory contents for an interrupted store are undefined.
- mem_en is never asserted in IDLE. At most one gnt and at most one rvalid are high in any cycle.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - An up-counter (saturating at STARVE_MAX) increments on each LS grant made while if_req=1.
  - It clears on any IF grant, or in any IDLE cycle with if_req=0.
  - When the counter equals STARVE_MAX and both requesters are active, IF wins.
- Undefined:
  - Strict LS priority; the counter logic is absent and IF can starve indefinitely.

Decomposition:
- Shared package (arb_pkg):
  - FSM state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - Owner encoding: OWN_IF=1'b0, OWN_LS=1'b1.
  - Default MEM_LAT and STARVE_MAX constants.
- One natural sub-module, arb_wait_counter: the loadable down-counter with a zero flag.
- The grant/FSM logic stays in the top level.

Test Plan:
- Reset defaults: after reset, if_req=1, addr 0x0000_0010, MEM_LAT=2 -> if_gnt at cycle 1; mem_en high cycles 2-3 with mem_addr=0x10; if_rvalid at cycle 4 with if_rdata=mem_rdata from cycle 3.
- Contention: both requests active in IDLE, ls_we=0, ls_addr=0x100 -> ls_gnt only. IF is granted in the IDLE cycle after ls_rvalid; mem_addr never mixes the two addresses.
- Store: ls_we=1, ls_mask=4'b0011, ls_wdata=0xDEADBEEF -> mem_we=1, mem_mask=0011 for exactly MEM_LAT cycles; ls_rvalid pulses once; ls_rdata unchanged.
- Starvation (macro defined, STARVE_MAX=4): if_req held and ls_req held continuously -> the 5th grant goes to IF. With the macro undefined, IF is never granted.
- Async reset: rst asserted in the 1st ACCESS cycle -> mem_en=0 before the next clock edge; no rvalid pulse; the first grant after release behaves as in the reset-defaults scenario.
- Inputs ignored after grant: ls_addr changes from 0x200 to 0x300 during ACCESS -> mem_addr stays 0x200 throughout.
